// File: rtl/cp0_defs.sv
// rtl/cp0_defs.sv - CP0 register numbers, exception codes and Status/Cause field positions.
package cp0_defs;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_NONE = 5'h1f;

    localparam int STATUS_IE      = 0;
    localparam int STATUS_EXL     = 1;
    localparam int STATUS_IM_LO   = 8;
    localparam int STATUS_IM_HI   = 15;
    localparam int CAUSE_BD       = 31;
    localparam int CAUSE_TI       = 30;
    localparam int CAUSE_IP_HW_LO = 10;
    localparam int CAUSE_IP_HI    = 15;
    localparam int CAUSE_IP_SW_LO = 8;
    localparam int CAUSE_IP_SW_HI = 9;
    localparam int CAUSE_EXC_LO   = 2;
    localparam int CAUSE_EXC_HI   = 6;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    // Only address-error exceptions carry a meaningful faulting address.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer; timer interrupt enabled by CP0_TIMER_INT_EN.
module cp0_timer
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic        tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = tick_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        if (count_we_i) begin
            tick_d  = 1'b0;
            count_d = wdata_i;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic timer_int_q, timer_int_d;

    // A write to either timer register suppresses a match on the same edge.
    always_comb begin
        timer_int_d = timer_int_q;
        if (compare_we_i) begin
            timer_int_d = 1'b0;
        end else if (!count_we_i && (count_q == compare_q) && (compare_q != 32'd0)) begin
            timer_int_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_int_q <= 1'b0;
        end else begin
            timer_int_q <= timer_int_d;
        end
    end

    assign timer_int_o = timer_int_q;
`else
    assign timer_int_o = 1'b0;
`endif

    assign count_o   = count_q;
    assign compare_o = compare_q;

endmodule

// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - CP0 register file: exception/ERET commit, MTC0/MFC0, timer (CP0_TIMER_INT_EN).
module cp0_reg
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [4:0]  exception_code,
    input  logic        exception_flush,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] pcM,
    input  logic [31:0] badvaddrM,
    input  logic        eret_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        wr_en;
    logic        timer_int;

    // A flushed instruction must not commit its MTC0.
    assign wr_en = we_i && !exception_flush && !eret_i;

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (wr_en && (waddr_i == CP0_COUNT)),
        .compare_we_i (wr_en && (waddr_i == CP0_COMPARE)),
        .wdata_i      (data_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int)
    );

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        cause_d[CAUSE_IP_HI:CAUSE_IP_HW_LO] = {int_i[5] | timer_int, int_i[4:0]};
        // TI is not stored here; it is overlaid from the timer on output.
        cause_d[CAUSE_TI] = 1'b0;

        if (exception_flush) begin
            if (!status_q[STATUS_EXL]) begin
                epc_d             = is_in_delayslot_i ? pcM - 32'd4 : pcM;
                cause_d[CAUSE_BD] = is_in_delayslot_i;
            end
            status_d[STATUS_EXL]                 = 1'b1;
            cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO]   = exception_code;
            if (is_addr_exc(exception_code)) begin
                badvaddr_d = badvaddrM;
            end
        end else if (eret_i) begin
            status_d[STATUS_EXL] = 1'b0;
        end else if (wr_en) begin
            case (waddr_i)
                CP0_STATUS: begin
                    status_d[STATUS_IM_HI:STATUS_IM_LO] = data_i[STATUS_IM_HI:STATUS_IM_LO];
                    status_d[STATUS_EXL]                = data_i[STATUS_EXL];
                    status_d[STATUS_IE]                 = data_i[STATUS_IE];
                end
                CP0_CAUSE: begin
                    cause_d[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO] = data_i[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO];
                end
                CP0_EPC: epc_d = data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q | {1'b0, timer_int, 30'd0};
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = timer_int;

    always_comb begin
        case (raddr_i)
            CP0_BADVADDR: data_o = badvaddr_q;
            CP0_COUNT:    data_o = count_o;
            CP0_COMPARE:  data_o = compare_o;
            CP0_STATUS:   data_o = status_q;
            CP0_CAUSE:    data_o = cause_o;
            CP0_EPC:      data_o = epc_q;
            CP0_PRID:     data_o = PRID_VAL;
            CP0_CONFIG:   data_o = CONFIG_VAL;
            default:      data_o = 32'd0;
        endcase
    end

endmodule
